host_req_sched: RTL and testbench
=================================

# host_req_sched

Schedules host cache-line read requests for all streams onto the single host request port. Each stream holds its own fetch address range and a credit count of free L2 lines. The block picks one eligible stream per cycle in round-robin order and issues line-aligned effective addresses until the range is exhausted. It sits between the functional stream-reset path and the host request interface, next to the L2 controller, which returns a credit each time an L2 line is freed.

## Interface
- addr_width, 64, host address width in bits
- cache_line, 128, host cache-line size in bytes (power of two)
- nstrms, 64, number of streams
- max_crd, 16, per-stream credits (free L2 lines) after configuration
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_cfg_v  in  1  stream configuration valid
- i_cfg_r  out  1  configuration ready
- i_cfg_sid  in  clog2(nstrms)  stream being configured
- i_cfg_ea_b  in  addr_width  first byte address of range
- i_cfg_ea_e  in  addr_width  last byte address of range (inclusive)
- i_crd_v  in  nstrms  one returned credit per asserted bit, per cycle
- o_req_v  out  1  host request valid
- o_req_r  in  1  host request ready
- o_req_sid  out  clog2(nstrms)  requesting stream
- o_req_ea  out  addr_width  line-aligned request address
- o_done  out  nstrms  level; stream has issued its last line

## Operation
- Per-stream state: IDLE, ACTIVE, DONE, plus ea_nxt, ea_last, crd.
  - ea_nxt and ea_last are line-aligned, addr_width bits.
  - crd is clog2(max_crd+1) bits.
- Line alignment: clear the low clog2(cache_line) bits.
- Configuration handshake completes when i_cfg_v && i_cfg_r. i_cfg_r is 1 whenever reset is low.
- On a completed configuration of stream s:
  - ea_nxt = align(ea_b), ea_last = align(ea_e), crd = max_crd, o_done[s] = 0.
  - State becomes ACTIVE.
  - If align(ea_e) < align(ea_b) (unsigned), state becomes DONE instead and o_done[s] = 1 with zero requests.
- Configuring any stream in any state overrides that stream's state and restarts it.
- Eligibility: the stream is ACTIVE and crd > 0.
- Arbitration runs when the output stage is empty, or full with o_req_r = 1.
  - Search for the first eligible sid starting at rr_ptr, wrapping modulo nstrms.
  - On a grant to sid g: the output stage loads {g, ea_nxt[g]}, rr_ptr = g+1 mod nstrms, crd[g] -= 1.
  - If ea_nxt[g] == ea_last[g], stream g becomes DONE and o_done[g] = 1. Otherwise ea_nxt[g] += cache_line.
- Credit return: crd[s] += 1 for each asserted i_crd_v[s]. It saturates at max_crd; excess is dropped.
- Grant and credit return on the same stream in the same cycle leave crd unchanged.
- Configuration and grant on the same stream in the same cycle:
  - The grant uses the pre-configuration values.
  - The configuration values win for state, ea_nxt, crd and o_done.
- Credit return on a stream in the same cycle as its configuration is dropped; crd = max_crd.
- A request already held in the output stage is not cancelled by reconfiguration of its stream.
- Credits on IDLE or DONE streams are still counted but have no effect.

## Timing
- Reset values:
  - o_req_v = 0, o_req_sid = 0, o_req_ea = 0, o_done = 0.
  - All streams IDLE, all crd = 0, rr_ptr = 0.
  - i_cfg_r = 0 while reset is high.
- Configuration accepted at edge t; the stream is eligible in cycle t+1; the earliest o_req_v is at cycle t+2.
- The output stage is one register. o_req_sid and o_req_ea hold stable while o_req_v && !o_req_r.
- Full throughput: with o_req_r held at 1, one request per cycle with no bubble.
- A credit returned at edge t makes the stream eligible in cycle t+1.
- Reset asserted mid-operation clears everything asynchronously, including a pending output request.
- Address arithmetic wraps modulo 2^addr_width. Termination is by equality with ea_last only.

## Test plan
- Configure sid 3, ea_b = 0x1000, ea_e = 0x11FF (cache_line 128), o_req_r = 1:
  - Four requests 0x1000, 0x1080, 0x1100, 0x1180 on consecutive cycles, starting 2 cycles after acceptance.
  - o_done[3] rises with the last grant.
- Configure sid 0, range of 20 lines, no credit return:
  - Exactly 16 requests, then o_req_v = 0.
  - Pulse i_crd_v[0] once → exactly one more request, at 0x800 offset.
- Configure sids 1, 2 and 5, all long ranges, o_req_r = 1: grants rotate 1, 2, 5, 1, 2, 5.
- Hold o_req_r = 0 for 5 cycles with o_req_v high: sid and ea are unchanged. On release the next stream is granted with no lost request.
- Configure sid 7 with ea_e = 0x0FFF < ea_b = 0x1000: no request, and o_done[7] = 1 the cycle after acceptance.
- Assert reset while sid 4 is mid-range:
  - o_req_v and o_done clear immediately.
  - After reset deasserts, no request is issued until sid 4 is reconfigured.

Source files
------------

// File: rtl/host_req_sched.sv
// Round-robin host cache-line read request scheduler across all streams.
// Each stream walks a line-aligned address range, gated by per-stream L2 line credits.
//
// state     | meaning
// st_idle   | stream not configured since reset
// st_active | stream has lines left to request
// st_done   | last line of the range has been granted
module host_req_sched #(
    parameter int addr_width = 64,
    parameter int cache_line = 128,
    parameter int nstrms     = 64,
    parameter int max_crd    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_cfg_v,
    output logic                      i_cfg_r,
    input  logic [$clog2(nstrms)-1:0] i_cfg_sid,
    input  logic [addr_width-1:0]     i_cfg_ea_b,
    input  logic [addr_width-1:0]     i_cfg_ea_e,
    input  logic [nstrms-1:0]         i_crd_v,
    output logic                      o_req_v,
    input  logic                      o_req_r,
    output logic [$clog2(nstrms)-1:0] o_req_sid,
    output logic [addr_width-1:0]     o_req_ea,
    output logic [nstrms-1:0]         o_done
);

    localparam int sid_w = $clog2(nstrms);
    localparam int crd_w = $clog2(max_crd + 1);

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_active = 2'd1;
    localparam logic [1:0] st_done   = 2'd2;

    localparam logic [addr_width-1:0] line_mask = addr_width'(cache_line - 1);
    localparam logic [addr_width-1:0] line_inc  = addr_width'(cache_line);
    localparam logic [crd_w-1:0]      crd_full  = crd_w'(max_crd);

    logic [1:0]            st      [nstrms];
    logic [addr_width-1:0] ea_nxt  [nstrms];
    logic [addr_width-1:0] ea_last [nstrms];
    logic [crd_w-1:0]      crd     [nstrms];

    logic [sid_w-1:0]      rr_ptr;
    logic [nstrms-1:0]     elig;
    logic                  gnt_v;
    logic [sid_w-1:0]      gnt_sid;
    logic                  adv;
    logic                  cfg_fire;
    logic [addr_width-1:0] cfg_b;
    logic [addr_width-1:0] cfg_e;

    assign i_cfg_r  = ~reset;
    assign cfg_fire = i_cfg_v & i_cfg_r;
    assign cfg_b    = i_cfg_ea_b & ~line_mask;
    assign cfg_e    = i_cfg_ea_e & ~line_mask;
    assign adv      = ~o_req_v | o_req_r;

    always_comb begin
        elig   = '0;
        o_done = '0;
        for (int s = 0; s < nstrms; s++) begin
            elig[s]   = (st[s] == st_active) && (crd[s] != '0);
            o_done[s] = (st[s] == st_done);
        end
    end

    // First eligible stream at or after rr_ptr, wrapping modulo nstrms.
    always_comb begin
        logic [sid_w:0] cand;
        cand    = '0;
        gnt_v   = 1'b0;
        gnt_sid = '0;
        for (int i = 0; i < nstrms; i++) begin
            cand = {1'b0, rr_ptr} + (sid_w + 1)'(i);
            if (cand >= (sid_w + 1)'(nstrms)) begin
                cand = cand - (sid_w + 1)'(nstrms);
            end
            if (!gnt_v && elig[cand[sid_w-1:0]]) begin
                gnt_v   = 1'b1;
                gnt_sid = cand[sid_w-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int s = 0; s < nstrms; s++) begin
                st[s]      <= st_idle;
                ea_nxt[s]  <= '0;
                ea_last[s] <= '0;
                crd[s]     <= '0;
            end
        end else begin
            if (adv && gnt_v) begin
                rr_ptr <= (gnt_sid == sid_w'(nstrms - 1)) ? '0 : gnt_sid + sid_w'(1);
            end
            for (int s = 0; s < nstrms; s++) begin
                // Configuration overrides any same-cycle grant or credit on this stream.
                if (cfg_fire && (i_cfg_sid == sid_w'(s))) begin
                    ea_nxt[s]  <= cfg_b;
                    ea_last[s] <= cfg_e;
                    crd[s]     <= crd_full;
                    st[s]      <= (cfg_e < cfg_b) ? st_done : st_active;
                end else if (adv && gnt_v && (gnt_sid == sid_w'(s))) begin
                    if (!i_crd_v[s]) begin
                        crd[s] <= crd[s] - crd_w'(1);
                    end
                    if (ea_nxt[s] == ea_last[s]) begin
                        st[s] <= st_done;
                    end else begin
                        ea_nxt[s] <= ea_nxt[s] + line_inc;
                    end
                end else if (i_crd_v[s] && (crd[s] != crd_full)) begin
                    crd[s] <= crd[s] + crd_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req_v   <= 1'b0;
            o_req_sid <= '0;
            o_req_ea  <= '0;
        end else if (adv) begin
            o_req_v <= gnt_v;
            if (gnt_v) begin
                o_req_sid <= gnt_sid;
                o_req_ea  <= ea_nxt[gnt_sid];
            end
        end
    end

endmodule

// File: tb/tb_host_req_sched.sv
// Bench for host_req_sched: table of single-stream ranges plus credit, rotation,
// back-pressure and mid-run reset sequences, checked through an in-order scoreboard.
module tb_host_req_sched;

    localparam int AW = 64;
    localparam int NS = 64;
    localparam int CL = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_cfg_v = 1'b0;
    logic          i_cfg_r;
    logic [5:0]    i_cfg_sid = '0;
    logic [AW-1:0] i_cfg_ea_b = '0;
    logic [AW-1:0] i_cfg_ea_e = '0;
    logic [NS-1:0] i_crd_v = '0;
    logic          o_req_v;
    logic          o_req_r = 1'b1;
    logic [5:0]    o_req_sid;
    logic [AW-1:0] o_req_ea;
    logic [NS-1:0] o_done;

    host_req_sched #(
        .addr_width(AW), .cache_line(CL), .nstrms(NS), .max_crd(16)
    ) dut (
        .clk(clk), .reset(reset),
        .i_cfg_v(i_cfg_v), .i_cfg_r(i_cfg_r), .i_cfg_sid(i_cfg_sid),
        .i_cfg_ea_b(i_cfg_ea_b), .i_cfg_ea_e(i_cfg_ea_e),
        .i_crd_v(i_crd_v),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
        .o_req_ea(o_req_ea), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    sid;
        logic [AW-1:0] ea;
    } exp_t;

    typedef struct {
        logic [5:0]    sid;
        logic [AW-1:0] ea_b;
        logic [AW-1:0] ea_e;
        logic [AW-1:0] first_ea;
        int            nreq;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nxfer = 0;
    int   xcyc[1024];

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_req_v === 1'b1 && o_req_r === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got sid %0d ea 0x%0h, expected no request", o_req_sid, o_req_ea);
            end else begin
                mon_e = sb_q.pop_front();
                chk("req_sid", AW'(o_req_sid), AW'(mon_e.sid));
                chk("req_ea", o_req_ea, mon_e.ea);
            end
            if (nxfer < 1024) xcyc[nxfer] = cyc;
            nxfer++;
        end
    end

    task automatic push_lines(input logic [5:0] sid, input logic [AW-1:0] first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.sid = sid;
            e.ea  = first + AW'(k * CL);
            sb_q.push_back(e);
        end
    endtask

    task automatic do_cfg(input logic [5:0] sid, input logic [AW-1:0] b, input logic [AW-1:0] e,
                          output int acc);
        @(posedge clk); #1;
        i_cfg_v = 1'b1; i_cfg_sid = sid; i_cfg_ea_b = b; i_cfg_ea_e = e;
        @(posedge clk); #1;
        acc = cyc;
        i_cfg_v = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", AW'(sb_q.size()), '0);
    endtask

    task automatic wait_xfers(input int base, input int cnt, input int budget);
        int n = 0;
        while ((nxfer - base) < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_wait", AW'((nxfer - base) >= cnt), 1);
    endtask

    initial begin
        int acc, st0, st1;
        exp_t e;

        vecs[0] = '{6'd3,  64'h1000, 64'h11FF, 64'h1000, 4};
        vecs[1] = '{6'd9,  64'h2045, 64'h2045, 64'h2000, 1};
        vecs[2] = '{6'd63, 64'h007F, 64'h0300, 64'h0000, 7};
        vecs[3] = '{6'd7,  64'h1000, 64'h0FFF, 64'h0000, 0};
        vecs[4] = '{6'd12, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00, 2};
        vecs[5] = '{6'd20, 64'h5000, 64'h57FF, 64'h5000, 16};

        #1 reset = 1'b1;
        #2;
        chk("rst_req_v", AW'(o_req_v), 0);
        chk("rst_req_sid", AW'(o_req_sid), 0);
        chk("rst_req_ea", o_req_ea, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cfg_r", AW'(i_cfg_r), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("cfg_r_out_of_reset", AW'(i_cfg_r), 1);

        for (int i = 0; i < 6; i++) begin
            st0 = nxfer;
            push_lines(vecs[i].sid, vecs[i].first_ea, vecs[i].nreq);
            do_cfg(vecs[i].sid, vecs[i].ea_b, vecs[i].ea_e, acc);
            chk($sformatf("v%0d_done_at_accept", i), AW'(o_done[vecs[i].sid]), AW'(vecs[i].nreq == 0));
            wait_drain(100);
            if (vecs[i].nreq > 0) begin
                chk($sformatf("v%0d_first_cycle", i), AW'(xcyc[st0]), AW'(acc + 1));
                chk($sformatf("v%0d_last_cycle", i), AW'(xcyc[st0 + vecs[i].nreq - 1]), AW'(acc + vecs[i].nreq));
            end
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle_after", i), AW'(o_req_v), 0);
            chk($sformatf("v%0d_done", i), AW'(o_done[vecs[i].sid]), 1);
            chk($sformatf("v%0d_count", i), AW'(nxfer - st0), AW'(vecs[i].nreq));
        end

        // Credit exhaustion on a 20-line range, then one returned credit.
        st0 = nxfer;
        push_lines(6'd0, 64'h0, 16);
        do_cfg(6'd0, 64'h0, 64'(20 * CL - 1), acc);
        wait_drain(100);
        repeat (5) @(posedge clk);
        #1;
        chk("crd_stall_req_v", AW'(o_req_v), 0);
        chk("crd_stall_count", AW'(nxfer - st0), 16);
        push_lines(6'd0, 64'h800, 1);
        @(posedge clk); #1 i_crd_v = 64'h1;
        @(posedge clk); #1 i_crd_v = '0;
        wait_drain(50);
        repeat (4) @(posedge clk);
        #1;
        chk("crd_one_more_count", AW'(nxfer - st0), 17);
        chk("crd_not_done", AW'(o_done[0]), 0);

        // Rotation across sids 1, 2, 5 with a 5-cycle back-pressure window.
        st0 = nxfer;
        o_req_r = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e.sid = 6'd1; e.ea = 64'h10000 + AW'(k * CL); sb_q.push_back(e);
            e.sid = 6'd2; e.ea = 64'h20000 + AW'(k * CL); sb_q.push_back(e);
            e.sid = 6'd5; e.ea = 64'h50000 + AW'(k * CL); sb_q.push_back(e);
        end
        do_cfg(6'd1, 64'h10000, 64'h103FF, acc);
        do_cfg(6'd2, 64'h20000, 64'h203FF, acc);
        do_cfg(6'd5, 64'h50000, 64'h503FF, acc);
        @(posedge clk); #1 o_req_r = 1'b1;
        wait_xfers(st0, 6, 50);
        @(posedge clk); #1 o_req_r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_req_v", AW'(o_req_v), 1);
            chk("hold_sid", AW'(o_req_sid), AW'(sb_q[0].sid));
            chk("hold_ea", o_req_ea, sb_q[0].ea);
        end
        @(posedge clk); #1 o_req_r = 1'b1;
        wait_drain(100);
        repeat (3) @(posedge clk);
        #1 chk("rr_count", AW'(nxfer - st0), 24);

        // Reset mid-range on sid 4.
        st0 = nxfer;
        push_lines(6'd4, 64'h40000, 10);
        do_cfg(6'd4, 64'h40000, 64'h404FF, acc);
        wait_xfers(st0, 3, 50);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_req_v", AW'(o_req_v), 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_cfg_r", AW'(i_cfg_r), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        st1 = nxfer;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_req", AW'(nxfer - st1), 0);
        chk("postrst_req_v", AW'(o_req_v), 0);
        push_lines(6'd4, 64'h40000, 2);
        do_cfg(6'd4, 64'h40000, 64'h400FF, acc);
        wait_drain(50);
        repeat (3) @(posedge clk);
        #1;
        chk("reconf_count", AW'(nxfer - st1), 2);
        chk("reconf_done", AW'(o_done[4]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule
